// File: rtl/asic_iopoc_pkg.sv
// Shared types and constants for the asic_iopoc power-on-control sequencer.
// Optional glitch filter in the synchronizers is enabled by ASIC_IOPOC_FILTER_EN.
package asic_iopoc_pkg;

   typedef enum logic [1:0] {
      ST_HOLD      = 2'd0,
      ST_WAIT_CORE = 2'd1,
      ST_SETTLE    = 2'd2,
      ST_READY     = 2'd3
   } iopoc_state_t;

   // Values visible on the debug state port.
   localparam logic [1:0] STATE_HOLD      = 2'd0;
   localparam logic [1:0] STATE_WAIT_CORE = 2'd1;
   localparam logic [1:0] STATE_SETTLE    = 2'd2;
   localparam logic [1:0] STATE_READY     = 2'd3;

   // Cycles a synchronized pgood must hold a new level before the filter follows it.
   localparam int FILT_LEN = 4;

endpackage

// File: rtl/asic_iopoc_sync.sv
// Reset-to-0 multi-flop synchronizer for one power-good input.
// With ASIC_IOPOC_FILTER_EN defined, a FILT_LEN-cycle glitch filter follows the flops.
module asic_iopoc_sync
   import asic_iopoc_pkg::*;
#(
   parameter int SYNCN = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic din,
   output logic dout
);

   logic [SYNCN-1:0] sync_reg;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNCN-2:0], din};
      end
   end

`ifdef ASIC_IOPOC_FILTER_EN
   localparam int FCW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);

   logic           filt_reg;
   logic           filt_next;
   logic [FCW-1:0] fcnt_reg;
   logic [FCW-1:0] fcnt_next;

   // The run counter restarts whenever the raw value agrees with the filtered one.
   always_comb begin
      filt_next = filt_reg;
      fcnt_next = '0;
      if (sync_reg[SYNCN-1] != filt_reg) begin
         if (fcnt_reg == FILT_LAST) begin
            filt_next = sync_reg[SYNCN-1];
         end else begin
            fcnt_next = fcnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         filt_reg <= 1'b0;
         fcnt_reg <= '0;
      end else begin
         filt_reg <= filt_next;
         fcnt_reg <= fcnt_next;
      end
   end

   assign dout = filt_reg;
`else
   assign dout = sync_reg[SYNCN-1];
`endif

endmodule

// File: rtl/asic_iopoc.sv
// Power-on-control sequencer: holds padring IOs safe until both supplies settle.
// ASIC_IOPOC_FILTER_EN adds a glitch filter on each synchronized pgood.
module asic_iopoc
   import asic_iopoc_pkg::*;
#(
   parameter int SETTLE = 16,
   parameter int SYNCN  = 2,
   parameter int FW     = 4
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          io_pgood,
   input  logic          core_pgood,
   input  logic          clr_fault,
   output logic          poc,
   output logic          ready,
   output logic [1:0]    state,
   output logic [FW-1:0] fault_count
);

   localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_LAST = (SETTLE == 0) ? '0 : CW'(SETTLE - 1);
   localparam logic [FW-1:0] FC_MAX = '1;

   logic [1:0] pgood_raw;
   logic [1:0] pgood_s;
   logic       iog;
   logic       cog;

   assign pgood_raw = {core_pgood, io_pgood};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         asic_iopoc_sync #(
            .SYNCN (SYNCN)
         ) u_sync (
            .clk    (clk),
            .nreset (nreset),
            .din    (pgood_raw[gi]),
            .dout   (pgood_s[gi])
         );
      end
   endgenerate

   assign iog = pgood_s[0];
   assign cog = pgood_s[1];

   iopoc_state_t  state_reg;
   iopoc_state_t  state_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic [FW-1:0] fc_reg;
   logic [FW-1:0] fc_next;
   logic          poc_reg;
   logic          ready_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      fc_next    = fc_reg;
      case (state_reg)
         ST_HOLD: begin
            if (iog) begin
               state_next = ST_WAIT_CORE;
            end
         end
         ST_WAIT_CORE: begin
            if (!iog) begin
               state_next = ST_HOLD;
            end else if (cog) begin
               state_next = ST_SETTLE;
               cnt_next   = '0;
            end
         end
         ST_SETTLE: begin
            cnt_next = cnt_reg + 1'b1;
            // Supply loss beats completion; the partial count is thrown away.
            if (!iog || !cog) begin
               state_next = ST_HOLD;
               cnt_next   = '0;
            end else if ((SETTLE == 0) || (cnt_reg == SETTLE_LAST)) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            if (!iog || !cog) begin
               state_next = ST_HOLD;
               if (fc_reg != FC_MAX) begin
                  fc_next = fc_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_HOLD;
         end
      endcase
      if (clr_fault) begin
         fc_next = '0;
      end
   end

   // Outputs are decoded from the next state so they change with the state register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_reg <= ST_HOLD;
         cnt_reg   <= '0;
         fc_reg    <= '0;
         poc_reg   <= 1'b1;
         ready_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         fc_reg    <= fc_next;
         poc_reg   <= (state_next != ST_READY);
         ready_reg <= (state_next == ST_READY);
      end
   end

   assign poc         = poc_reg;
   assign ready       = ready_reg;
   assign state       = state_reg;
   assign fault_count = fc_reg;

endmodule

// File: tb/tb_asic_iopoc.sv
// Directed self-checking bench for asic_iopoc (default parameters).
// Filter-specific vectors run only when ASIC_IOPOC_FILTER_EN is defined.
module tb_asic_iopoc;
   import asic_iopoc_pkg::*;

   localparam int SYNCN  = 2;
   localparam int SETTLE = 16;
   localparam int FW     = 4;
`ifdef ASIC_IOPOC_FILTER_EN
   localparam int FD = 4;
`else
   localparam int FD = 0;
`endif

   logic          clk = 1'b0;
   logic          nreset;
   logic          io_pgood;
   logic          core_pgood;
   logic          clr_fault;
   logic          poc;
   logic          ready;
   logic [1:0]    state;
   logic [FW-1:0] fault_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   always #5 clk = ~clk;

   asic_iopoc #(
      .SETTLE (SETTLE),
      .SYNCN  (SYNCN),
      .FW     (FW)
   ) dut (
      .clk         (clk),
      .nreset      (nreset),
      .io_pgood    (io_pgood),
      .core_pgood  (core_pgood),
      .clr_fault   (clr_fault),
      .poc         (poc),
      .ready       (ready),
      .state       (state),
      .fault_count (fault_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   function automatic logic [31:0] sel_sig(input int sel);
      case (sel)
         0:       return 32'(state);
         1:       return 32'(poc);
         2:       return 32'(ready);
         default: return 32'(fault_count);
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until the selected output reaches val; the final check fails on timeout.
   task automatic wait_for(input string tag, input int sel, input logic [31:0] val,
                           input int budget, output int cycles);
      cycles = 0;
      while (sel_sig(sel) !== val && cycles < budget) begin
         tick(1);
         cycles++;
      end
      chk(tag, sel_sig(sel), val);
   endtask

   task automatic do_reset(input logic io, input logic core);
      nreset     = 1'b0;
      io_pgood   = io;
      core_pgood = core;
      clr_fault  = 1'b0;
      tick(2);
      nreset = 1'b1;
   endtask

   initial begin
      nreset     = 1'b0;
      io_pgood   = 1'b1;
      core_pgood = 1'b1;
      clr_fault  = 1'b0;
      tick(3);
      chk("rst_poc", 32'(poc), 1);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_state", 32'(state), 32'(STATE_HOLD));
      chk("rst_fc", 32'(fault_count), 0);

      nreset = 1'b1;
      wait_for("pwrup_poc", 1, 0, 60, cyc);
      chk("pwrup_latency", cyc, SYNCN + 2 + SETTLE + FD);
      chk("pwrup_ready", 32'(ready), 1);
      chk("pwrup_state", 32'(state), 32'(STATE_READY));

      // Ordered power-up: io first, core ten cycles later.
      do_reset(1'b0, 1'b0);
      io_pgood = 1'b1;
      wait_for("ord_wait_core", 0, 32'(STATE_WAIT_CORE), 30, cyc);
      chk("ord_wc_latency", cyc, SYNCN + 1 + FD);
      tick(10 - cyc);
      chk("ord_still_wc", 32'(state), 32'(STATE_WAIT_CORE));
      core_pgood = 1'b1;
      wait_for("ord_settle", 0, 32'(STATE_SETTLE), 30, cyc);
      chk("ord_settle_latency", cyc, SYNCN + 1 + FD);
      chk("ord_poc_in_settle", 32'(poc), 1);
      wait_for("ord_poc", 1, 0, 40, cyc);
      chk("ord_settle_len", cyc, SETTLE);

      // Brown-out mid-SETTLE.
      do_reset(1'b1, 1'b1);
      wait_for("bo_settle", 0, 32'(STATE_SETTLE), 30, cyc);
      tick(8);
      core_pgood = 1'b0;
      wait_for("bo_hold", 0, 32'(STATE_HOLD), 20, cyc);
      chk("bo_poc", 32'(poc), 1);
      chk("bo_fc", 32'(fault_count), 0);
      core_pgood = 1'b1;
      wait_for("bo_resettle", 0, 32'(STATE_SETTLE), 30, cyc);
      wait_for("bo_poc_fall", 1, 0, 40, cyc);
      chk("bo_settle_len", cyc, SETTLE);
      chk("bo_fc_after", 32'(fault_count), 0);

      // Repeated loss in READY, saturating the counter.
      for (int i = 1; i <= 20; i++) begin
         io_pgood = 1'b0;
         wait_for("loss_poc", 1, 1, 20, cyc);
         if (i == 1) chk("loss_latency", cyc, SYNCN + 1 + FD);
         chk("loss_fc", 32'(fault_count), (i > 15) ? 15 : i);
         io_pgood = 1'b1;
         wait_for("loss_rearm", 2, 1, 60, cyc);
      end

      // clr_fault coincident with a loss wins.
      io_pgood = 1'b0;
      tick(SYNCN + FD);
      chk("clrloss_pre_state", 32'(state), 32'(STATE_READY));
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("clrloss_state", 32'(state), 32'(STATE_HOLD));
      chk("clrloss_fc", 32'(fault_count), 0);

      // clr_fault on its own.
      io_pgood = 1'b1;
      wait_for("clr_rearm", 2, 1, 60, cyc);
      io_pgood = 1'b0;
      wait_for("clr_loss", 1, 1, 20, cyc);
      chk("clr_fc_before", 32'(fault_count), 1);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("clr_fc_after", 32'(fault_count), 0);

      // Asynchronous reset mid-cycle while READY.
      io_pgood = 1'b1;
      wait_for("arst_ready", 2, 1, 60, cyc);
      #3;
      nreset = 1'b0;
      #1;
      chk("arst_poc", 32'(poc), 1);
      chk("arst_ready", 32'(ready), 0);
      chk("arst_state", 32'(state), 32'(STATE_HOLD));
      nreset = 1'b1;
      tick(1);

`ifdef ASIC_IOPOC_FILTER_EN
      wait_for("filt_ready", 2, 1, 60, cyc);
      core_pgood = 1'b0;
      tick(3);
      core_pgood = 1'b1;
      tick(15);
      chk("filt_3cyc_state", 32'(state), 32'(STATE_READY));
      chk("filt_3cyc_fc", 32'(fault_count), 0);
      core_pgood = 1'b0;
      tick(4);
      core_pgood = 1'b1;
      wait_for("filt_4cyc_state", 0, 32'(STATE_HOLD), 20, cyc);
      chk("filt_4cyc_fc", 32'(fault_count), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
